// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer + debouncer giving levels, edge pulses and a wrapping change count.
// Optional long-press detection is built when CTRL_LONGPRESS_EN is defined.
module input_conditioner #(
    parameter int                  CHANNELS         = 4,
    parameter int                  SYNC_STAGES      = 2,
    parameter int                  DEBOUNCE_CYCLES  = 270000,
    parameter logic [CHANNELS-1:0] IDLE_LEVEL       = '0,
    parameter int                  LONGPRESS_CYCLES = 27000000
) (
    input  logic                clk27,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in_async,
    output logic [CHANNELS-1:0] in_state,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [7:0]          change_cnt
);
    localparam int db_w = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [db_w-1:0]     db_cnt [CHANNELS];
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] accept;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE_LEVEL;
        end else begin
            sync_q[0] <= in_async;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++)
            accept[i] = (s[i] != in_state[i]) && (db_cnt[i] == db_w'(DEBOUNCE_CYCLES - 1));
    end

    // Any sample matching the current level restarts the count: no partial credit.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) db_cnt[i] <= '0;
            in_state   <= IDLE_LEVEL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            change_cnt <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                db_cnt[i] <= (s[i] == in_state[i] || accept[i]) ? '0 : db_cnt[i] + 1'b1;
            in_state   <= in_state ^ accept;
            rise_pulse <= accept & s;
            fall_pulse <= accept & ~s;
            change_cnt <= change_cnt + {7'd0, |accept};
        end
    end

`ifdef CTRL_LONGPRESS_EN
    localparam int lp_w = $clog2(LONGPRESS_CYCLES + 1);

    logic [lp_w-1:0] hold_cnt [CHANNELS];

    // Hold counter saturates at the threshold so each press yields a single pulse.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) hold_cnt[i] <= '0;
            long_pulse <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                hold_cnt[i]   <= (in_state[i] == IDLE_LEVEL[i]) ? '0 :
                                 (hold_cnt[i] == lp_w'(LONGPRESS_CYCLES)) ? hold_cnt[i] : hold_cnt[i] + 1'b1;
                long_pulse[i] <= (in_state[i] != IDLE_LEVEL[i]) && (hold_cnt[i] == lp_w'(LONGPRESS_CYCLES - 1));
            end
        end
    end
`else
    assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed table, corner sequences and random stimulus against a history-window model.
module tb_input_conditioner;
    localparam int S = 2;
    localparam int D = 4;
    localparam int L = 10;
    localparam logic [3:0] IDLE = 4'b0000;
`ifdef CTRL_LONGPRESS_EN
    localparam logic LEXP = 1'b1;
`else
    localparam logic LEXP = 1'b0;
`endif

    logic       clk27 = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_async = 4'b0000;
    logic [3:0] in_state, rise_pulse, fall_pulse, long_pulse;
    logic [7:0] change_cnt;

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .IDLE_LEVEL(IDLE), .LONGPRESS_CYCLES(L)
    ) dut (
        .clk27(clk27), .reset_n(reset_n), .in_async(in_async),
        .in_state(in_state), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .long_pulse(long_pulse), .change_cnt(change_cnt)
    );

    always #5 clk27 = ~clk27;

    int checks = 0;
    int failures = 0;
    int long_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronized samples all differ from it.
    logic [3:0] hist [64];
    int         ecnt;
    int         press_edge [4];
    logic [3:0] m_state, m_rise, m_fall, m_long;
    logic [7:0] m_cnt;

    always @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 64; k++) hist[k] <= IDLE;
            ecnt    <= 0;
            m_state <= IDLE;
            m_rise  <= '0;
            m_fall  <= '0;
            m_long  <= '0;
            m_cnt   <= '0;
        end else begin : step
            int         cur;
            logic       ok;
            logic [3:0] acc, lp;
            cur = ecnt + 1;
            acc = '0;
            lp  = '0;
            for (int c = 0; c < 4; c++) begin
                ok = 1'b1;
                for (int k = 0; k < D; k++)
                    if (hist[(cur - S - k) & 63][c] == m_state[c]) ok = 1'b0;
                acc[c] = ok;
                if (ok && m_state[c] == IDLE[c]) press_edge[c] <= cur;
                lp[c] = LEXP && (m_state[c] != IDLE[c]) && (cur - press_edge[c] == L);
            end
            hist[cur & 63] <= in_async;
            ecnt    <= cur;
            m_state <= m_state ^ acc;
            m_rise  <= acc & ~m_state;
            m_fall  <= acc & m_state;
            m_long  <= lp;
            m_cnt   <= m_cnt + ((|acc) ? 8'd1 : 8'd0);
        end
    end

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk27);
            #2;
            if (long_pulse[0]) long_seen++;
            chk("model", {8'd0, in_state, rise_pulse, fall_pulse, long_pulse, change_cnt},
                {8'd0, m_state, m_rise, m_fall, m_long, m_cnt});
        end
    endtask

    typedef struct {
        logic [3:0] in;
        int         cycles;
        logic [3:0] st;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{4'b0001, 5, 4'b0000, 4'b0000, 4'b0000, 8'd0};
        tbl[1] = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 8'd1};
        tbl[2] = '{4'b0000, 6, 4'b0000, 4'b0000, 4'b0001, 8'd2};
        tbl[3] = '{4'b0010, 3, 4'b0000, 4'b0000, 4'b0000, 8'd2};
        tbl[4] = '{4'b0000, 2, 4'b0000, 4'b0000, 4'b0000, 8'd2};
        tbl[5] = '{4'b0010, 6, 4'b0010, 4'b0010, 4'b0000, 8'd3};
        tbl[6] = '{4'b0111, 6, 4'b0111, 4'b0101, 4'b0000, 8'd4};
        tbl[7] = '{4'b0000, 6, 4'b0000, 4'b0000, 4'b0111, 8'd5};

        // Reset with inputs active, then release and expect a debounced rise on all channels.
        reset_n  = 1'b0;
        in_async = 4'b1111;
        tick(3);
        chk("reset_state", in_state, 4'b0000);
        chk("reset_pulses", {rise_pulse, fall_pulse, long_pulse}, 12'd0);
        chk("reset_cnt", change_cnt, 8'd0);
        reset_n = 1'b1;
        tick(5);
        chk("release_early", in_state, 4'b0000);
        tick(1);
        chk("release_rise", rise_pulse, 4'b1111);
        chk("release_cnt", change_cnt, 8'd1);
        tick(1);
        chk("release_rise_1cyc", rise_pulse, 4'b0000);

        reset_n  = 1'b0;
        in_async = 4'b0000;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        for (int v = 0; v < 8; v++) begin
            in_async = tbl[v].in;
            tick(tbl[v].cycles);
            chk($sformatf("tbl%0d_state", v), in_state, tbl[v].st);
            chk($sformatf("tbl%0d_rise", v), rise_pulse, tbl[v].rise);
            chk($sformatf("tbl%0d_fall", v), fall_pulse, tbl[v].fall);
            chk($sformatf("tbl%0d_cnt", v), change_cnt, tbl[v].cnt);
        end

        // Long press: one pulse exactly L cycles after the rise.
        in_async = 4'b0001;
        tick(6);
        chk("lp_rise", rise_pulse, 4'b0001);
        long_seen = 0;
        tick(9);
        chk("lp_early", long_seen, 0);
        tick(1);
        chk("lp_at_l", long_pulse, {3'b000, LEXP});
        tick(5);
        chk("lp_once", long_seen, {31'd0, LEXP});
        in_async = 4'b0000;
        tick(6);
        long_seen = 0;
        in_async = 4'b0001;
        tick(8);
        in_async = 4'b0000;
        tick(8);
        chk("lp_short", long_seen, 0);

        // Reset while ch3 is mid-debounce and ch0 is already high.
        in_async = 4'b0001;
        tick(6);
        in_async = 4'b1001;
        tick(4);
        reset_n = 1'b0;
        #1;
        chk("midrst_state", in_state, IDLE);
        chk("midrst_pulses", {rise_pulse, fall_pulse}, 8'd0);
        chk("midrst_cnt", change_cnt, 8'd0);
        tick(2);
        in_async = 4'b0000;
        reset_n  = 1'b1;
        tick(8);
        chk("midrst_after", {in_state, rise_pulse, change_cnt}, 16'd0);

        // Drive change_cnt to 255 then wrap.
        for (int k = 0; k < 255; k++) begin
            in_async[3] = ~in_async[3];
            tick(6);
        end
        chk("cnt_255", change_cnt, 8'd255);
        in_async[3] = ~in_async[3];
        tick(6);
        chk("cnt_wrap", change_cnt, 8'd0);

        for (int k = 0; k < 400; k++) begin
            in_async = 4'($urandom);
            tick($urandom_range(1, 9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
